// File: rtl/vrf_pkg.sv
// vrf_pkg: default parameters and sweep/idle state encoding for the vector register file
package vrf_pkg;
  localparam int VRF_NUM_REGS = 32;
  localparam int VRF_LANES = 4;
  localparam int VRF_WIDTH = 32;
  localparam int VRF_ZERO_REG0 = 1;
  typedef enum logic {CLEAR, IDLE} vrf_state_t;
endpackage

// File: rtl/vrf_lane_bank.sv
// vrf_lane_bank: one lane of storage, two async read ports and one write port
module vrf_lane_bank import vrf_pkg::*; #(
  parameter int NUM_REGS = VRF_NUM_REGS,
  parameter int WIDTH = VRF_WIDTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic [$clog2(NUM_REGS)-1:0] ra1,
  input  logic [$clog2(NUM_REGS)-1:0] ra2,
  output logic [WIDTH-1:0]            rd1,
  output logic [WIDTH-1:0]            rd2
);
  logic [WIDTH-1:0] mem [NUM_REGS];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/vector_regfile_v2.sv
// vector_regfile_v2: multi-lane vector register file with clear sweep, per-lane bypass and registered reads
module vector_regfile_v2 import vrf_pkg::*; #(
  parameter int NUM_REGS = VRF_NUM_REGS,
  parameter int LANES = VRF_LANES,
  parameter int WIDTH = VRF_WIDTH,
  parameter int ZERO_REG0 = VRF_ZERO_REG0,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1 [LANES],
  output logic [WIDTH-1:0] rd_data2 [LANES],
  output logic             rd_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_mask,
  input  logic             wr_bcast,
  input  logic [WIDTH-1:0] wr_data [LANES]
);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  vrf_state_t state, state_nx;
  logic [AW-1:0] clr_cnt, clr_cnt_nx;
  logic op, wr_zero, rd_zero1, rd_zero2;
  logic [LANES-1:0] wr_en;
  logic [WIDTH-1:0] byp1 [LANES];
  logic [WIDTH-1:0] byp2 [LANES];
  assign ready = state == IDLE;
  assign op = ready && !clr_req;
  assign wr_zero = ZERO_REG0 != 0 && wr_addr == '0;
  assign rd_zero1 = ZERO_REG0 != 0 && rd_addr1 == '0;
  assign rd_zero2 = ZERO_REG0 != 0 && rd_addr2 == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  always_comb begin
    state_nx = state == CLEAR ? (clr_cnt == LAST ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    clr_cnt_nx = state == CLEAR ? clr_cnt + 1'b1 : '0;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] wd, bank_rd1, bank_rd2;
    assign wr_en[i] = op && wr_mask[i] && !wr_zero;
    assign wd = wr_bcast ? wr_data[0] : wr_data[i];
    // the sweep owns the write port whenever the file is not idle
    vrf_lane_bank #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_bank (
      .clk(clk),
      .we(ready ? wr_en[i] : 1'b1),
      .wa(ready ? wr_addr : clr_cnt),
      .wd(ready ? wd : '0),
      .ra1(rd_addr1),
      .ra2(rd_addr2),
      .rd1(bank_rd1),
      .rd2(bank_rd2)
    );
    assign byp1[i] = rd_zero1 ? '0 : (wr_en[i] && wr_addr == rd_addr1 ? wd : bank_rd1);
    assign byp2[i] = rd_zero2 ? '0 : (wr_en[i] && wr_addr == rd_addr2 ? wd : bank_rd2);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data1 <= '{default: '0};
      rd_data2 <= '{default: '0};
    end else begin
      rd_valid <= op && rd_en;
      if (op && rd_en) begin
        rd_data1 <= byp1;
        rd_data2 <= byp2;
      end
    end
endmodule

// File: doc/vector_regfile_v2.md
VECTOR_REGFILE_V2 -- requirements
Module: vector_regfile_v2

Interface
REQ-001 SHALL have parameter NUM_REGS, 32, number of vector registers (power of 2, >=4).
REQ-002 SHALL have parameter LANES, 4, lanes per vector.
REQ-003 SHALL have parameter WIDTH, 32, bits per lane.
REQ-004 SHALL have parameter ZERO_REG0, 1, 1 = register 0 reads as zero and ignores writes.
REQ-005 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have clr_req  input  1  pulse requesting zeroing of all registers.
REQ-008 SHALL have ready  output  1  high when idle and accepting reads/writes.
REQ-009 SHALL have rd_en  input  1  read request, both ports.
REQ-010 SHALL have rd_addr1, rd_addr2  input  $clog2(NUM_REGS) each  read addresses.
REQ-011 SHALL have rd_data1, rd_data2  output  [WIDTH-1:0] x LANES unpacked each  registered read data.
REQ-012 SHALL have rd_valid  output  1  rd_data1/rd_data2 valid this cycle.
REQ-013 SHALL have wr_addr  input  $clog2(NUM_REGS)  write address.
REQ-014 SHALL have wr_mask  input  LANES  per-lane write enable.
REQ-015 SHALL have wr_bcast  input  1  1 = lane 0 of wr_data written to every masked lane.
REQ-016 SHALL have wr_data  input  [WIDTH-1:0] x LANES unpacked  write data.

Function
REQ-017 SHALL use FSM states CLEAR and IDLE; ready = (state == IDLE).
REQ-018 SHALL in CLEAR write zero to all lanes of register clr_cnt each cycle, clr_cnt from 0 to NUM_REGS-1, then enter IDLE the following cycle.
REQ-019 SHALL enter CLEAR with clr_cnt = 0 when clr_req is high in IDLE; clr_req in CLEAR is ignored.
REQ-020 SHALL ignore rd_en and wr_mask while in CLEAR, including the cycle clr_req is accepted.
REQ-021 SHALL in IDLE write lane i of wr_addr when wr_mask[i] = 1, data = wr_bcast ? wr_data[0] : wr_data[i].
REQ-022 SHALL have read latency 1: rd_en in IDLE at edge N sets rd_valid = 1 and updates rd_data1/2 after edge N; rd_en = 0 sets rd_valid = 0 and holds rd_data.
REQ-023 SHALL bypass per lane: same-cycle write with wr_addr == rd_addrX and wr_mask[i] = 1 returns the write value for lane i, stored value for other lanes.
REQ-024 SHALL when ZERO_REG0 = 1 return zero for address 0, suppress writes and bypass to address 0.
REQ-025 SHALL allow rd_addr1 == rd_addr2 with identical results on both ports.

Reset
REQ-026 SHALL on rst_n low asynchronously set state = CLEAR, clr_cnt = 0, ready = 0, rd_valid = 0, rd_data1/2 = 0.
REQ-027 SHALL not reset storage arrays; zeroing is done only by the CLEAR sweep after rst_n deasserts.
REQ-028 SHALL abandon a sweep in progress on reset assertion and restart it from 0 after deassertion.

Structure
REQ-029 SHALL place default parameter values and the state enum (CLEAR, IDLE) in package vrf_pkg.
REQ-030 SHALL instantiate one sub-module vrf_lane_bank per lane: 2 read ports, 1 write port, one WIDTH x NUM_REGS array.
REQ-031 SHALL keep the FSM, bypass muxes and output registers in vector_regfile_v2.

Verification
REQ-032 SHALL cover reset release with defaults: ready low 32 cycles, high at cycle 33; read of r5 then returns 0 on all lanes.
REQ-033 SHALL cover wr_addr 7, mask 4'b0101, data {4,3,2,1} then read r7: {0,3,0,1}; with wr_bcast = 1 and the same mask: {0,1,0,1}.
REQ-034 SHALL cover same-cycle write r9 mask 4'b0010 data lane1 = 32'hDEAD with read r9 (stored {1,1,1,1}): returns {1,1,32'hDEAD,1} next cycle.
REQ-035 SHALL cover ZERO_REG0 = 1: write r0 all lanes 32'hFFFF_FFFF, then read r0 on both ports: all zero, rd_valid 1.
REQ-036 SHALL cover clr_req after filling r1..r31: ready low 32 cycles, writes during the sweep dropped, all reads return 0 afterwards.
REQ-037 SHALL cover rst_n asserted at sweep count 10: ready 0 and rd_valid 0 immediately; after release a full 32-cycle sweep precedes ready.
